// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stopwatch_pkg                                                      |
// | Shared constants, direction enum and per-digit modulus helper.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package stopwatch_pkg;

  localparam int BCD_W   = 4;
  localparam int MOD_DEC = 10;
  localparam int MOD_SEX = 6;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Digits 1 and 3 are the tens of seconds and tens of minutes in mm:ss.
  function automatic int dig_mod(input int i, input int mm_ss);
    return ((mm_ss != 0) && ((i == 1) || (i == 3))) ? MOD_SEX : MOD_DEC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bcd_digit_step                                                     |
// | Combinational single BCD digit up/down step with carry/borrow.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bcd_digit_step
  import stopwatch_pkg::*;
#(
  parameter int L = 10
) (
  input  logic [BCD_W-1:0] a,
  input  logic             step,
  input  dir_e             dir,
  output logic [BCD_W-1:0] next,
  output logic             carry
);

  localparam logic [BCD_W-1:0] C_MAX = BCD_W'(L - 1);

  always_comb begin
    next  = a;
    carry = 1'b0;
    if (step) begin
      if (dir == DIR_UP) begin
        if (a == C_MAX) begin
          next  = '0;
          carry = 1'b1;
        end else begin
          next = a + 1'b1;
        end
      end else begin
        if (a == '0) begin
          next  = C_MAX;
          carry = 1'b1;
        end else begin
          next = a - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_counter_n.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stopwatch_counter_n                                                |
// | N-digit BCD up/down time counter with prescaler, preset load,      |
// | wrap/saturate and optional lap capture (STOPWATCH_COUNTER_LAP_EN). |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module stopwatch_counter_n
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int TICK_HZ  = 1,
  parameter int NDIG     = 4,
  parameter int MM_SS    = 1,
  parameter int SAT      = 0
) (
  input  logic                  clk,
  input  logic                  init_regs,
  input  logic                  count_enabled,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*NDIG-1:0]     load_val,
  input  logic                  lap,
  output logic [4*NDIG-1:0]     time_reading,
  output logic [4*NDIG-1:0]     lap_reading,
  output logic                  lap_valid,
  output logic                  at_limit,
  output logic                  tick_out
);

  localparam int DIV   = CLK_FREQ / TICK_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int W     = BCD_W * NDIG;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_time;
  logic [W-1:0]     w_next;
  logic [W-1:0]     w_load;
  logic [NDIG:0]    w_step;
  logic [NDIG-1:0]  w_is_max;
  logic [NDIG-1:0]  w_is_zero;
  logic             w_tick;
  logic             w_hold;
  logic             w_unused_carry;
  dir_e             w_dir;

  assign w_dir          = dir_e'(dir);
  assign w_tick         = (r_cnt == C_CNT_LAST) & count_enabled & ~init_regs;
  assign w_step[0]      = w_tick;
  assign w_unused_carry = w_step[NDIG];

  generate
    for (genvar i = 0; i < NDIG; i++) begin : g_digit
      localparam int MOD = dig_mod(i, MM_SS);
      localparam logic [BCD_W-1:0] C_MAX = BCD_W'(MOD - 1);

      logic [BCD_W-1:0] w_cur;
      logic [BCD_W-1:0] w_ld;

      assign w_cur = r_time[i*BCD_W +: BCD_W];
      assign w_ld  = load_val[i*BCD_W +: BCD_W];

      bcd_digit_step #(
        .L (MOD)
      ) u_step (
        .a     (w_cur),
        .step  (w_step[i]),
        .dir   (w_dir),
        .next  (w_next[i*BCD_W +: BCD_W]),
        .carry (w_step[i+1])
      );

      // Out-of-range preset digits clamp to the digit's maximum.
      assign w_load[i*BCD_W +: BCD_W] = (w_ld > C_MAX) ? C_MAX : w_ld;
      assign w_is_max[i]  = (w_cur == C_MAX);
      assign w_is_zero[i] = (w_cur == '0);
    end
  endgenerate

  assign at_limit = (w_dir == DIR_DOWN) ? (&w_is_zero) : (&w_is_max);
  assign w_hold   = (SAT != 0) && at_limit;
  assign tick_out = w_tick;

  always_ff @(posedge clk) begin
    if (init_regs) begin
      r_cnt <= '0;
    end else if (load || w_tick) begin
      r_cnt <= '0;
    end else if (count_enabled) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (init_regs) begin
      r_time <= '0;
    end else if (load) begin
      r_time <= w_load;
    end else if (w_tick && !w_hold) begin
      r_time <= w_next;
    end
  end

  assign time_reading = r_time;

`ifdef STOPWATCH_COUNTER_LAP_EN
  logic [W-1:0] r_lap;
  logic         r_lap_valid;

  always_ff @(posedge clk) begin
    if (init_regs) begin
      r_lap       <= '0;
      r_lap_valid <= 1'b0;
    end else if (lap) begin
      r_lap       <= r_time;
      r_lap_valid <= 1'b1;
    end
  end

  assign lap_reading = r_lap;
  assign lap_valid   = r_lap_valid;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign lap_reading  = '0;
  assign lap_valid    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter_n.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_stopwatch_counter_n                                             |
// | Wrap and saturate instances checked against a seconds-count model. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_stopwatch_counter_n;

  localparam int NDIG  = 4;
  localparam int DIV   = 4;
  localparam int TOTAL = 3600;

  logic        clk;
  logic        rst;
  logic        en;
  logic        dir;
  logic        load;
  logic [15:0] load_val;
  logic        lap;

  logic [15:0] time_r [2];
  logic [15:0] lap_r  [2];
  logic        lapv   [2];
  logic        atl    [2];
  logic        tick   [2];

  int n_checks = 0;
  int n_err    = 0;

  stopwatch_counter_n #(
    .CLK_FREQ (4), .TICK_HZ (1), .NDIG (NDIG), .MM_SS (1), .SAT (0)
  ) u_dut_wrap (
    .clk (clk), .init_regs (rst), .count_enabled (en), .dir (dir),
    .load (load), .load_val (load_val), .lap (lap),
    .time_reading (time_r[0]), .lap_reading (lap_r[0]),
    .lap_valid (lapv[0]), .at_limit (atl[0]), .tick_out (tick[0])
  );

  stopwatch_counter_n #(
    .CLK_FREQ (4), .TICK_HZ (1), .NDIG (NDIG), .MM_SS (1), .SAT (1)
  ) u_dut_sat (
    .clk (clk), .init_regs (rst), .count_enabled (en), .dir (dir),
    .load (load), .load_val (load_val), .lap (lap),
    .time_reading (time_r[1]), .lap_reading (lap_r[1]),
    .lap_valid (lapv[1]), .at_limit (atl[1]), .tick_out (tick[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mod_of(input int i);
    return ((i == 1) || (i == 3)) ? 6 : 10;
  endfunction

  // Model value is elapsed ticks as a plain integer in 0..TOTAL-1.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < NDIG; i++) begin
      r[i*4 +: 4] = 4'(x % mod_of(i));
      x = x / mod_of(i);
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    int v;
    int d;
    v = 0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      d = int'(b[i*4 +: 4]);
      if (d >= mod_of(i)) d = mod_of(i) - 1;
      v = v * mod_of(i) + d;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  int          m_v    [2];
  logic [15:0] m_lap  [2];
  logic        m_lapv [2];
  int          m_cnt;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    bit t;
    t = (m_cnt == DIV - 1) && en && !rst;
    if (rst) begin
      m_cnt   = 0;
      m_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_v[k]    = 0;
        m_lap[k]  = '0;
        m_lapv[k] = 1'b0;
      end
    end else begin
`ifdef STOPWATCH_COUNTER_LAP_EN
      if (lap) begin
        for (int k = 0; k < 2; k++) begin
          m_lap[k]  = to_bcd(m_v[k]);
          m_lapv[k] = 1'b1;
        end
      end
`endif
      if (load) begin
        m_cnt = 0;
        for (int k = 0; k < 2; k++) m_v[k] = from_bcd(load_val);
      end else if (t) begin
        m_cnt = 0;
        for (int k = 0; k < 2; k++) begin
          if (!dir) begin
            if (m_v[k] == TOTAL - 1) begin
              if (k == 0) m_v[k] = 0;
            end else begin
              m_v[k] = m_v[k] + 1;
            end
          end else begin
            if (m_v[k] == 0) begin
              if (k == 0) m_v[k] = TOTAL - 1;
            end else begin
              m_v[k] = m_v[k] - 1;
            end
          end
        end
      end else if (en) begin
        m_cnt = m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic exp_tick;
      logic exp_lim;
      exp_tick = (m_cnt == DIV - 1) && en && !rst;
      for (int k = 0; k < 2; k++) begin
        exp_lim = dir ? (m_v[k] == 0) : (m_v[k] == TOTAL - 1);
        chk($sformatf("model_time[%0d]", k), 32'(time_r[k]), 32'(to_bcd(m_v[k])));
        chk($sformatf("model_tick[%0d]", k), 32'(tick[k]), 32'(exp_tick));
        chk($sformatf("model_limit[%0d]", k), 32'(atl[k]), 32'(exp_lim));
        chk($sformatf("model_lap[%0d]", k), 32'(lap_r[k]), 32'(m_lap[k]));
        chk($sformatf("model_lapv[%0d]", k), 32'(lapv[k]), 32'(m_lapv[k]));
      end
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    load_val = v;
    run(1);
    load     = 1'b0;
  endtask

  int n_ticks;
`ifdef STOPWATCH_COUNTER_LAP_EN
  localparam logic LAP_ON = 1'b1;
`else
  localparam logic LAP_ON = 1'b0;
`endif

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0; lap = 1'b0;
    run(1);
    chk("reset_time", 32'(time_r[0]), 32'h0000);
    chk("reset_limit", 32'(atl[0]), 32'h0);
    chk("reset_lapv", 32'(lapv[0]), 32'h0);
    rst = 1'b0;
    en  = 1'b1;

    // 240 enabled cycles give 60 ticks, i.e. one minute.
    n_ticks = 0;
    for (int i = 0; i < 240; i++) begin
      if (tick[0]) n_ticks++;
      run(1);
    end
    chk("up_tick_count", 32'(n_ticks), 32'd60);
    chk("up_one_minute", 32'(time_r[0]), 32'h0100);

    do_load(16'h5959);
    chk("load_max", 32'(time_r[0]), 32'h5959);
    chk("limit_up", 32'(atl[1]), 32'h1);
    run(3);
    chk("sat_tick_pulse", 32'(tick[1]), 32'h1);
    run(1);
    chk("wrap_up", 32'(time_r[0]), 32'h0000);
    chk("sat_up_hold", 32'(time_r[1]), 32'h5959);
    chk("sat_up_limit", 32'(atl[1]), 32'h1);

    dir = 1'b1;
    do_load(16'h0100);
    run(4);
    chk("down_borrow", 32'(time_r[0]), 32'h0059);
    do_load(16'h0000);
    chk("limit_down", 32'(atl[0]), 32'h1);
    run(4);
    chk("wrap_down", 32'(time_r[0]), 32'h5959);
    chk("sat_down_hold", 32'(time_r[1]), 32'h0000);

    dir = 1'b0;
    do_load(16'h0000);
    run(2);
    en = 1'b0;
    run(10);
    chk("pause_hold", 32'(time_r[0]), 32'h0000);
    en = 1'b1;
    run(1);
    chk("resume_tick", 32'(tick[0]), 32'h1);
    run(1);
    chk("resume_step", 32'(time_r[0]), 32'h0001);

    do_load(16'h0009);
    run(3);
    lap = 1'b1;
    run(1);
    lap = 1'b0;
    chk("lap_step", 32'(time_r[0]), 32'h0010);
    chk("lap_value", 32'(lap_r[0]), LAP_ON ? 32'h0009 : 32'h0000);
    chk("lap_valid", 32'(lapv[0]), 32'(LAP_ON));
    run(2);
    rst = 1'b1;
    dir = 1'b1;
    run(1);
    rst = 1'b0;
    chk("midreset_time", 32'(time_r[0]), 32'h0000);
    chk("midreset_lapv", 32'(lapv[0]), 32'h0);
    chk("midreset_lap", 32'(lap_r[0]), 32'h0000);
    chk("midreset_limit", 32'(atl[0]), 32'h1);
    dir = 1'b0;

    do_load(16'h7A7A);
    chk("load_clamp", 32'(time_r[0]), 32'h5959);
    lap = 1'b1;
    run(1);
    lap = 1'b0;
    chk("lap_gate", 32'(lapv[1]), 32'(LAP_ON));

    dir = 1'b1;
    run(40);
    dir = 1'b0;
    run(60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_counter_n.md
# stopwatch_counter_n

Parametrised multi-digit BCD time counter. It generalises the single-purpose two-digit seconds counter to N digits with mixed decimal/sexagesimal moduli, up/down counting, preset load, wrap or saturate at the limit, and an optional lap-capture register. It sits between the front-panel control FSM (enable, direction, load, lap) and the seven-segment display driver, which consumes `time_reading`.

## Interface
- `CLK_FREQ`, default 100000000: input clock in Hz.
- `TICK_HZ`, default 1: count rate in Hz. `CLK_FREQ % TICK_HZ` must be 0. `DIV = CLK_FREQ/TICK_HZ`.
- `NDIG`, default 4: number of BCD digits, 1..8.
- `MM_SS`, default 1: 1 gives digits 1 and 3 modulus 6 (mm:ss); all other digits, and every digit when 0, use modulus 10.
- `SAT`, default 0: 0 wraps at the limit; 1 holds at the limit.

Ports:
- `clk` in 1: single clock, rising edge.
- `init_regs` in 1: synchronous active-high reset.
- `count_enabled` in 1: runs the prescaler and digits.
- `dir` in 1: 0 counts up, 1 counts down.
- `load` in 1: one-cycle preset strobe.
- `load_val` in 4*NDIG: preset value, BCD.
- `lap` in 1: one-cycle capture strobe.
- `time_reading` out 4*NDIG: current value; digit 0 is the LSBs.
- `lap_reading` out 4*NDIG: captured value.
- `lap_valid` out 1: a capture has occurred since reset.
- `at_limit` out 1: value equals all-max (dir=0) or all-zero (dir=1). Combinational from registers and `dir`.
- `tick_out` out 1: one-cycle pulse on every counting tick.

## Operation
- **Prescaler.** Width is max(1, $clog2(DIV)). It counts 0..DIV-1 only while `count_enabled`=1, and holds otherwise.
- **Tick.** `tick = (cnt == DIV-1) & count_enabled & ~init_regs`. On a tick the prescaler returns to 0. With DIV=1, every enabled cycle is a tick.
- **Digit chain.** Digit i steps when digit i-1 carries or borrows; digit 0 steps on tick.
- **Up.** A digit at modulus-1 goes to 0 and carries.
- **Down.** A digit at 0 goes to modulus-1 and borrows.
- **Limit.**
  - With SAT=0: an up step from all-max produces all-zero, and a down step from all-zero produces all-max.
  - With SAT=1: the digit registers hold at the limit. The prescaler keeps running and `tick_out` still pulses.
- **Priority per edge.** `init_regs` > `load` > tick step.
  - `load` writes `load_val` to the digits and clears the prescaler, whether or not `count_enabled` is set.
  - A loaded digit >= its modulus is stored as modulus-1.
- **Direction change.** `dir` is sampled on the tick cycle only. Changing it never disturbs the prescaler.
- **Lap.** With the macro compiled in, `lap`=1 copies the current (pre-edge) `time_reading` into `lap_reading` and sets `lap_valid`=1.
  - If `lap` coincides with a tick or a load, the pre-step or pre-load value is captured.
  - `lap` during `init_regs` is ignored.

## Timing
- **Reset.** `init_regs` drives all registers to 0 on the next edge. After that edge, every output reads 0 except `at_limit`, which reads `dir` (all-zero counts as the limit when dir=1).
- **Counting latency.** `time_reading` changes on the edge that ends the tick cycle, which is DIV enabled cycles after reset or load.
- **Enable.** When `count_enabled` falls mid-period, the partial count is retained. A period spans DIV enabled cycles in total.
- **Load latency.** `load` is visible on `time_reading` one edge later. The next tick arrives DIV enabled cycles after that.
- **Combinational outputs.** `tick_out` is high during the tick cycle itself, not registered. `at_limit` follows `dir` combinationally within the same cycle.

## Configuration
- The lap-capture feature is compiled in by `STOPWATCH_COUNTER_LAP_EN`.
- **Defined.** Lap capture operates as described under Operation.
- **Undefined.** The ports remain present. `lap` is ignored, and `lap_reading` and `lap_valid` are tied to 0. No capture flops are synthesised.

## Structure
- **Package `stopwatch_pkg`.**
  - Constants `BCD_W`=4, `MOD_DEC`=10, `MOD_SEX`=6.
  - Function `dig_mod(i, mm_ss)`, which returns each digit's modulus.
  - Enum for dir: `DIR_UP`, `DIR_DOWN`.
- **Sub-module `bcd_digit_step`.** A combinational single-digit cell.
  - Parameter: `L`.
  - Inputs: `a`, `step`, `dir`.
  - Outputs: `next`, `carry`.
  - Instantiated NDIG times in a generate loop, with `carry` chained into the next digit's `step`.
- **Saturation and load clamping** live in the top level.

## Test plan
1. **Up count with rollover.** CLK_FREQ=4, TICK_HZ=1, NDIG=4, MM_SS=1, enable held for 240 cycles → `tick_out` pulses every 4th cycle and `time_reading` reads 16'h0100 after the 60th tick.
2. **Up limit.** Load 16'h5959, dir=0, one tick → 16'h0000 with SAT=0. With SAT=1 the value holds at 16'h5959, `at_limit`=1, and `tick_out` still pulses.
3. **Down count and limit.** dir=1, load 16'h0100, one tick → 16'h0059. Load 16'h0000, one tick → 16'h5959 with SAT=0.
4. **Enable pause.** Drop `count_enabled` after 2 of 4 prescaler cycles and hold low for 10 cycles → no change. Re-enable → tick after 2 further cycles.
5. **Lap and reset.** Assert `lap` in the same cycle as the tick at value 16'h0009 → `lap_reading`=16'h0009, `lap_valid`=1, `time_reading`=16'h0010. Then assert `init_regs` mid-period → all zero next edge.
6. **Load clamp.** Load 16'h7A7A with MM_SS=1 → `time_reading`=16'h5959. With the lap macro undefined, pulse `lap` → `lap_valid` stays 0.
